// File: rtl/muldiv_iter_if.sv
// Issue-side request and writeback-side result channels of the muldiv unit.
// The master drives requests and out_ready; the slave is the execution unit.
interface muldiv_iter_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  src1;
    logic [XLEN-1:0]  src2;
    logic [12:0]      muldiv_type;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, src1, src2, muldiv_type, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, src1, src2, muldiv_type, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative RV64M mul/div unit: mul ready after MUL_STAGES+1 cycles, div after N+1 (1 with MULDIV_EARLY_OUT_EN).
// Single occupancy: in_ready only in IDLE; DONE holds the result until out_ready; flush kills any op.
module muldiv_iter #(
    parameter int XLEN       = 64,
    parameter int MUL_STAGES = 2,
    parameter int TAG_W      = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    muldiv_iter_if.slave io
);
    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    typedef struct packed {
        logic mul_hi;
        logic s1s;
        logic s2s;
        logic is_rem;
        logic word;
        logic dz;
        logic neg;
        logic rneg;
    } op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  src1_q, src1_d, src2_q, src2_d;
    logic [XLEN-1:0]  quo_q, quo_d, prem_q, prem_d, dsr_q, dsr_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sgn);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) r[i] = sgn & v[31];
        return r;
    endfunction

    // Lowest set type bit wins; 15 marks an all-zero type.
    logic [3:0] dec_idx;
    always_comb begin
        dec_idx = 4'd15;
        for (int i = 12; i >= 0; i--) begin
            if (io.muldiv_type[i]) dec_idx = 4'(i);
        end
    end

    logic dec_none, dec_mul, dec_sgn, dec_word;
    assign dec_none = (dec_idx == 4'd15);
    assign dec_mul  = dec_idx inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
    assign dec_sgn  = dec_idx inside {4'd4, 4'd6, 4'd9, 4'd11};
    assign dec_word = (XLEN == 64) && !dec_none && (dec_idx >= 4'd8);

    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
    assign a_ext = dec_word ? ext32(io.src1, dec_sgn) : io.src1;
    assign b_ext = dec_word ? ext32(io.src2, dec_sgn) : io.src2;
    assign a_mag = (dec_sgn && a_ext[XLEN-1]) ? -a_ext : a_ext;
    assign b_mag = (dec_sgn && b_ext[XLEN-1]) ? -b_ext : b_ext;

    // Extending to 2*XLEN before multiplying keeps the low 2*XLEN bits exact for every signedness.
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    assign mul_a = {{XLEN{op_q.s1s & src1_q[XLEN-1]}}, src1_q};
    assign mul_b = {{XLEN{op_q.s2s & src2_q[XLEN-1]}}, src2_q};
    assign prod  = mul_a * mul_b;

    logic [XLEN-1:0] mul_res;
    assign mul_res = op_q.mul_hi ? prod[2*XLEN-1:XLEN]
                   : (op_q.word ? ext32(prod[XLEN-1:0], 1'b1) : prod[XLEN-1:0]);

    logic [XLEN:0]   rem_sh;
    logic            rem_ge;
    logic [XLEN-1:0] prem_nx, quo_nx, q_fin, r_fin, div_sel, div_res;
    assign rem_sh  = {prem_q, quo_q[XLEN-1]};
    assign rem_ge  = rem_sh >= {1'b0, dsr_q};
    assign prem_nx = rem_ge ? XLEN'(rem_sh - {1'b0, dsr_q}) : rem_sh[XLEN-1:0];
    assign quo_nx  = {quo_q[XLEN-2:0], rem_ge};
    assign q_fin   = op_q.dz ? '1 : (op_q.neg ? -quo_nx : quo_nx);
    assign r_fin   = op_q.dz ? src1_q : (op_q.rneg ? -prem_nx : prem_nx);
    assign div_sel = op_q.is_rem ? r_fin : q_fin;
    assign div_res = op_q.word ? ext32(div_sel, 1'b1) : div_sel;

`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0] min_v, early_q, early_r, early_sel, early_res;
    logic            early_ovf, early_hit;
    always_comb begin
        min_v = '0;
        min_v[XLEN-1] = 1'b1;
        if (dec_word) min_v = ext32(min_v >> (XLEN - 32), 1'b1);
    end
    assign early_ovf = dec_sgn && (a_ext == min_v) && (b_ext == '1);
    assign early_hit = (b_ext == '0) || early_ovf || (a_mag < b_mag);
    assign early_q   = (b_ext == '0) ? '1 : (early_ovf ? a_ext : '0);
    assign early_r   = early_ovf ? '0 : a_ext;
    assign early_sel = (dec_idx inside {4'd6, 4'd7, 4'd11, 4'd12}) ? early_r : early_q;
    assign early_res = dec_word ? ext32(early_sel, 1'b1) : early_sel;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        quo_d    = quo_q;
        prem_d   = prem_q;
        dsr_d    = dsr_q;
        result_d = result_q;
        tag_d    = tag_q;
        case (state_q)
            IDLE: begin
                if (io.in_valid && !flush) begin
                    src1_d      = a_ext;
                    src2_d      = b_ext;
                    tag_d       = io.in_tag;
                    op_d.mul_hi = dec_idx inside {4'd1, 4'd2, 4'd3};
                    op_d.s1s    = dec_idx inside {4'd1, 4'd2};
                    op_d.s2s    = (dec_idx == 4'd1);
                    op_d.is_rem = dec_idx inside {4'd6, 4'd7, 4'd11, 4'd12};
                    op_d.word   = dec_word;
                    op_d.dz     = (b_ext == '0);
                    op_d.neg    = dec_sgn & (a_ext[XLEN-1] ^ b_ext[XLEN-1]);
                    op_d.rneg   = dec_sgn & a_ext[XLEN-1];
                    // W dividends sit at the top so their MSB is consumed first.
                    quo_d       = dec_word ? (a_mag << (XLEN - 32)) : a_mag;
                    prem_d      = '0;
                    dsr_d       = b_mag;
                    if (dec_none) begin
                        result_d = '0;
                        state_d  = DONE;
                    end else if (dec_mul) begin
                        cnt_d   = CNT_W'(MUL_STAGES - 1);
                        state_d = MUL;
                    end else begin
                        cnt_d   = dec_word ? CNT_W'(32) : CNT_W'(XLEN);
                        state_d = DIV;
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_hit) begin
                            result_d = early_res;
                            state_d  = DONE;
                        end
`endif
                    end
                end
            end
            MUL: begin
                if (cnt_q == '0) begin
                    result_d = mul_res;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV: begin
                quo_d  = quo_nx;
                prem_d = prem_nx;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    result_d = div_res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (io.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            quo_q    <= '0;
            prem_q   <= '0;
            dsr_q    <= '0;
            result_q <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            quo_q    <= quo_d;
            prem_q   <= prem_d;
            dsr_q    <= dsr_d;
            result_q <= result_d;
            tag_q    <= tag_d;
        end
    end

    assign io.in_ready   = (state_q == IDLE);
    assign io.out_valid  = (state_q == DONE);
    assign io.out_result = result_q;
    assign io.out_tag    = tag_q;
endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: vector table with a result scoreboard, then backpressure, flush and reset sequences.
module tb_muldiv_iter;
    localparam logic [12:0] T_MUL    = 13'h0001;
    localparam logic [12:0] T_MULH   = 13'h0002;
    localparam logic [12:0] T_MULHSU = 13'h0004;
    localparam logic [12:0] T_MULHU  = 13'h0008;
    localparam logic [12:0] T_DIV    = 13'h0010;
    localparam logic [12:0] T_DIVU   = 13'h0020;
    localparam logic [12:0] T_REM    = 13'h0040;
    localparam logic [12:0] T_REMU   = 13'h0080;
    localparam logic [12:0] T_MULW   = 13'h0100;
    localparam logic [12:0] T_DIVW   = 13'h0200;
    localparam logic [12:0] T_DIVUW  = 13'h0400;
    localparam logic [12:0] T_REMW   = 13'h0800;
    localparam logic [12:0] T_REMUW  = 13'h1000;
    localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [12:0] t;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
        bit          early;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic [5:0]  tag;
    } sb_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   errors = 0;
    int   checks = 0;
    sb_t  sb_q[$];
    vec_t vecs[24];

    muldiv_iter_if #(.XLEN(64), .TAG_W(6)) bus ();

    muldiv_iter #(.XLEN(64), .MUL_STAGES(2), .TAG_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .io    (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input vec_t v);
`ifdef MULDIV_EARLY_OUT_EN
        if (v.early) return 1;
`endif
        return v.lat;
    endfunction

    task automatic drive(input logic [12:0] t, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] tg, input string nm);
        @(negedge clock);
        check({nm, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.muldiv_type = t;
        bus.src1        = a;
        bus.src2        = b;
        bus.in_tag      = tg;
        bus.in_valid    = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; latency counts edges from accept to first out_valid.
    task automatic wait_out(input int exp_l, input bit pop, input string nm);
        int  lat;
        sb_t e;
        lat = 1;
        while (!bus.out_valid && lat < 300) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check({nm, "_latency"}, 64'(lat), 64'(exp_l));
        if (pop) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_scoreboard: output with no expected entry", nm);
            end else begin
                e = sb_q.pop_front();
                check({nm, "_result"}, bus.out_result, e.res);
                check({nm, "_tag"}, 64'(bus.out_tag), 64'(e.tag));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;
        vecs[0]  = '{T_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0};
        vecs[1]  = '{T_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   ONES,                    65, 1'b0};
        vecs[2]  = '{T_DIVU,   64'd100,                 64'd0,                   ONES,                    65, 1'b1};
        vecs[3]  = '{T_REM,    64'h1234,                64'd0,                   64'h1234,                65, 1'b1};
        vecs[4]  = '{T_DIV,    64'h8000_0000_0000_0000, ONES,                    64'h8000_0000_0000_0000, 65, 1'b1};
        vecs[5]  = '{T_REM,    64'h8000_0000_0000_0000, ONES,                    64'd0,                   65, 1'b1};
        vecs[6]  = '{T_MULW,   64'h7FFF_FFFF,           64'd2,                   64'hFFFF_FFFF_FFFF_FFFE, 3,  1'b0};
        vecs[7]  = '{T_MULHU,  ONES,                    ONES,                    64'hFFFF_FFFF_FFFF_FFFE, 3,  1'b0};
        vecs[8]  = '{T_MUL,    64'h1_0000_0001,         64'd3,                   64'h3_0000_0003,         3,  1'b0};
        vecs[9]  = '{T_MULH,   64'hFFFF_FFFF_FFFF_FFFE, 64'd3,                   ONES,                    3,  1'b0};
        vecs[10] = '{T_MULHSU, ONES,                    ONES,                    ONES,                    3,  1'b0};
        vecs[11] = '{T_DIVW,   64'hFFFF_FFF9,           64'd2,                   64'hFFFF_FFFF_FFFF_FFFD, 33, 1'b0};
        vecs[12] = '{T_DIVUW,  64'h1_8000_0000,         64'd1,                   64'hFFFF_FFFF_8000_0000, 33, 1'b0};
        vecs[13] = '{T_REMUW,  64'h5_0000_0007,         64'h3_0000_0004,         64'd3,                   33, 1'b0};
        vecs[14] = '{T_REMW,   64'hFFFF_FFF9,           64'h8_0000_0002,         ONES,                    33, 1'b0};
        vecs[15] = '{T_DIVU,   64'd100,                 64'd7,                   64'd14,                  65, 1'b0};
        vecs[16] = '{T_REMU,   64'd100,                 64'd7,                   64'd2,                   65, 1'b0};
        vecs[17] = '{T_DIV,    64'd5,                   ONES,                    64'hFFFF_FFFF_FFFF_FFFB, 65, 1'b0};
        vecs[18] = '{T_DIV,    64'd3,                   64'd10,                  64'd0,                   65, 1'b1};
        vecs[19] = '{13'h0000, 64'd55,                  64'd66,                  64'd0,                   1,  1'b0};
        vecs[20] = '{13'h0030, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0};
        vecs[21] = '{T_DIVW,   64'h8000_0000,           64'hFFFF_FFFF,           64'hFFFF_FFFF_8000_0000, 33, 1'b1};
        vecs[22] = '{T_DIVW,   64'd5,                   64'h1_0000_0000,         ONES,                    33, 1'b1};
        vecs[23] = '{T_REMUW,  64'h8000_0001,           64'd0,                   64'hFFFF_FFFF_8000_0001, 33, 1'b1};

        bus.in_valid    = 1'b0;
        bus.src1        = '0;
        bus.src2        = '0;
        bus.muldiv_type = '0;
        bus.in_tag      = '0;
        bus.out_ready   = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_out_result", bus.out_result, 64'd0);
        check("reset_out_tag", 64'(bus.out_tag), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            sb_q.push_back('{vecs[i].exp, 6'(i + 1)});
            drive(vecs[i].t, vecs[i].a, vecs[i].b, 6'(i + 1), $sformatf("vec%0d", i));
            wait_out(exp_lat(vecs[i]), 1'b1, $sformatf("vec%0d", i));
            @(posedge clock);
            #1;
        end

        // Result must stay parked while the consumer stalls.
        bus.out_ready = 1'b0;
        sb_q.push_back('{64'd14, 6'h2A});
        drive(T_DIVU, 64'd100, 64'd7, 6'h2A, "bp");
        wait_out(65, 1'b1, "bp");
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1;
            check($sformatf("bp_hold%0d_valid", c), 64'(bus.out_valid), 64'd1);
            check($sformatf("bp_hold%0d_result", c), bus.out_result, 64'd14);
            check($sformatf("bp_hold%0d_tag", c), 64'(bus.out_tag), 64'h2A);
            check($sformatf("bp_hold%0d_in_ready", c), 64'(bus.in_ready), 64'd0);
        end
        @(negedge clock);
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp_after_in_ready", 64'(bus.in_ready), 64'd1);
        check("bp_after_out_valid", 64'(bus.out_valid), 64'd0);

        // Flush in cycle T+20 of a divide, then a fresh MUL right away.
        drive(T_DIVU, 64'd1000, 64'd3, 6'h15, "flush_div");
        repeat (19) @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("flush_div_in_ready", 64'(bus.in_ready), 64'd1);
        check("flush_div_out_valid", 64'(bus.out_valid), 64'd0);
        sb_q.push_back('{64'd42, 6'h33});
        drive(T_MUL, 64'd6, 64'd7, 6'h33, "post_flush_mul");
        wait_out(3, 1'b1, "post_flush_mul");
        seen = 0;
        for (int c = 0; c < 70; c++) begin
            @(posedge clock);
            #1;
            if (bus.out_valid) seen++;
        end
        check("flushed_div_silent", 64'(seen), 64'd0);

        // A request presented together with flush is dropped.
        @(negedge clock);
        bus.muldiv_type = T_MUL;
        bus.src1        = 64'd2;
        bus.src2        = 64'd2;
        bus.in_tag      = 6'h07;
        bus.in_valid    = 1'b1;
        flush           = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock);
            #1;
            if (bus.out_valid) seen++;
        end
        check("flush_with_valid_dropped", 64'(seen), 64'd0);
        check("flush_with_valid_in_ready", 64'(bus.in_ready), 64'd1);

        // Flush in DONE discards the parked result.
        bus.out_ready = 1'b0;
        drive(T_MUL, 64'd6, 64'd7, 6'h05, "flush_done");
        wait_out(3, 1'b0, "flush_done");
        check("flush_done_held_result", bus.out_result, 64'd42);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("flush_done_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_done_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;

        // Asynchronous reset in the middle of a divide.
        drive(T_DIV, 64'd100, 64'd7, 6'h09, "reset_mid");
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("reset_mid_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_mid_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_mid_out_result", bus.out_result, 64'd0);
        check("reset_mid_out_tag", 64'(bus.out_tag), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
